i2s_rx_10xe_capture: RTL and testbench

I2S serial receiver that samples the serial clock, word-select and serial data lines of an I2S transmitter in the `aud_mclk` domain. It deserialises left/right samples MSB-first with the standard one-bit delay after each word-select change. It then packs each stereo pair into one word, buffers the pairs in a small FIFO and presents them on an AXI-Stream-style master port. It forms the capture end of the I2S link and is used as a loopback checker and receive path for the I2S transmitter.

---
 rtl/i2s_rx_10xe_capture.sv | 188 ++++++++++++++++++
 tb/tb_i2s_rx_10xe_capture.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_10xe_capture.sv
// I2S capture: synchronised sclk/ws/sd, MSB-first deserialiser, stereo-pair FWFT FIFO.
// Sticky irq is only built when I2S_RX_10XE_IRQ_EN is defined.
module i2s_rx_10xe_capture #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    aud_mclk,
    input  logic                    aud_mrst,
    input  logic                    sclk_in,
    input  logic                    lrclk_in,
    input  logic                    sdata_in,
    output logic [2*DATA_WIDTH-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    frame_err,
    output logic [7:0]              overflow_cnt,
    output logic                    irq,
    input  logic                    irq_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic lr_meta_q, lr_sync_q;
    logic sd_meta_q, sd_sync_q;
    logic sclk_rise, ws, sd;

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            lr_meta_q   <= 1'b0;
            lr_sync_q   <= 1'b0;
            sd_meta_q   <= 1'b0;
            sd_sync_q   <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_in;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            lr_meta_q   <= lrclk_in;
            lr_sync_q   <= lr_meta_q;
            sd_meta_q   <= sdata_in;
            sd_sync_q   <= sd_meta_q;
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign ws        = lr_sync_q;
    assign sd        = sd_sync_q;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic                  ws_prev_q, ws_prev_d;
    logic                  push;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        left_d    = left_q;
        ws_prev_d = ws_prev_q;
        frame_err = 1'b0;
        push      = 1'b0;
        if (sclk_rise) begin
            ws_prev_d = ws;
            case (state_q)
                ST_HUNT: begin
                    if (ws_prev_q && !ws) begin
                        bit_cnt_d = '0;
                        state_d   = ST_LEFT;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    if (ws == ws_prev_q) begin
                        // Bits past DATA_WIDTH are slot padding
                        if (bit_cnt_q < CNT_FULL) begin
                            shift_d   = {shift_q[DATA_WIDTH-2:0], sd};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            push      = (state_q == ST_RIGHT) &&
                                        (bit_cnt_q == CNT_LAST);
                        end
                    end else if (bit_cnt_q != CNT_FULL) begin
                        frame_err = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        bit_cnt_d = '0;
                        if (state_q == ST_LEFT) begin
                            left_d  = shift_q;
                            state_d = ST_RIGHT;
                        end else begin
                            state_d = ST_LEFT;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            state_q   <= ST_HUNT;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            left_q    <= '0;
            ws_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            left_q    <= left_d;
            ws_prev_q <= ws_prev_d;
        end
    end

    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW:0]             wr_ptr_q, rd_ptr_q;
    logic                    empty, full, pop, wr_en, drop;
    logic [7:0]              ovf_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop   = !empty && m_tready;
    // A same-cycle pop frees the slot the new pair needs
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge aud_mclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[PW-1:0]] <= {shift_d, left_q};
        end
    end

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop && ovf_q != 8'hFF) begin
                ovf_q <= ovf_q + 8'd1;
            end
        end
    end

    assign m_tvalid     = !empty;
    assign m_tdata      = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
    assign overflow_cnt = ovf_q;

`ifdef I2S_RX_10XE_IRQ_EN
    logic irq_q;

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            irq_q <= 1'b0;
        end else if (drop || frame_err) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;

    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_10xe_capture.sv
// Bench for i2s_rx_10xe_capture: directed scenarios plus randomized frames,
// all outputs compared every cycle against a sample-level model.
module tb_i2s_rx_10xe_capture;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
`ifdef I2S_RX_10XE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0, lr = 1'b0, sd = 1'b0;
    logic rdy = 1'b0, iclr = 1'b0;
    logic [2*DW-1:0] tdata;
    logic tvalid, ferr, irq;
    logic [7:0] ovf;

    i2s_rx_10xe_capture #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .aud_mclk(clk), .aud_mrst(rst),
        .sclk_in(sclk), .lrclk_in(lr), .sdata_in(sd),
        .m_tdata(tdata), .m_tvalid(tvalid), .m_tready(rdy),
        .frame_err(ferr), .overflow_cnt(ovf),
        .irq(irq), .irq_clr(iclr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: sample-level view of the link
    localparam int MH = 0, ML = 1, MR = 2;
    int md, cnt, m_ovf;
    bit wsp, m_irq;
    logic [DW-1:0] sh, lw;
    logic [2*DW-1:0] q[$];
    bit h_sc[3], h_lr[3], h_sd[3];
    bit m_pop, m_push, m_err, m_drop, m_w, m_d, m_rise;
    logic [2*DW-1:0] m_pd;

    function automatic bit short_now();
        return h_sc[1] && !h_sc[2] && md != MH && h_lr[1] != wsp && cnt != DW;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md = MH; cnt = 0; m_ovf = 0; wsp = 0; m_irq = 0;
            sh = '0; lw = '0; q.delete();
            for (int i = 0; i < 3; i++) begin
                h_sc[i] = 0; h_lr[i] = 0; h_sd[i] = 0;
            end
        end else begin
            m_pop  = (q.size() > 0) && rdy;
            m_push = 0;
            m_drop = 0;
            m_err  = short_now();
            m_rise = h_sc[1] && !h_sc[2];
            if (m_rise) begin
                m_w = h_lr[1];
                m_d = h_sd[1];
                if (md == MH) begin
                    if (wsp && !m_w) begin md = ML; cnt = 0; end
                end else if (m_w == wsp) begin
                    if (cnt < DW) begin
                        sh = (sh << 1) | DW'(m_d);
                        cnt++;
                        if (md == MR && cnt == DW) begin
                            m_push = 1;
                            m_pd = {sh, lw};
                        end
                    end
                end else if (m_err) begin
                    md = MH;
                end else begin
                    if (md == ML) begin lw = sh; md = MR; end
                    else md = ML;
                    cnt = 0;
                end
                wsp = m_w;
            end
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                if (q.size() < DEPTH) q.push_back(m_pd);
                else begin
                    m_drop = 1;
                    if (m_ovf < 255) m_ovf++;
                end
            end
            if (IRQ_ON && (m_err || m_drop)) m_irq = 1;
            else if (iclr) m_irq = 0;
            h_sc[2] = h_sc[1]; h_sc[1] = h_sc[0]; h_sc[0] = sclk;
            h_lr[2] = h_lr[1]; h_lr[1] = h_lr[0]; h_lr[0] = lr;
            h_sd[2] = h_sd[1]; h_sd[1] = h_sd[0]; h_sd[0] = sd;
        end
    end

    logic [2*DW-1:0] beats[$];
    int nerr = 0;

    always @(negedge clk) begin
        chk("tvalid", tvalid, q.size() > 0);
        chk("tdata", tdata, (q.size() > 0) ? q[0] : '0);
        chk("frame_err", ferr, !rst && short_now());
        chk("overflow_cnt", ovf, m_ovf);
        chk("irq", irq, m_irq);
        if (tvalid && rdy) beats.push_back(tdata);
        if (ferr) nerr++;
    end

    function automatic logic [63:0] beat(input int i);
        return (i < beats.size()) ? 64'(beats[i]) : 64'hDEAD;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sbit(input bit w, input bit d);
        lr = w; sd = d; sclk = 0;
        wait_cyc($urandom_range(3, 2));
        sclk = 1;
        wait_cyc($urandom_range(3, 2));
    endtask

    // Rise 0 of a slot carries the ws change; data MSB..LSB on rises 1..DW
    task automatic slot(input bit w, input logic [DW-1:0] v, input int len);
        for (int i = 0; i < len; i++)
            sbit(w, (i >= 1 && i <= DW) ? v[DW-i] : 1'($urandom));
    endtask

    task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        slot(0, l, 32);
        slot(1, r, 32);
    endtask

    task automatic do_reset();
        rst = 1;
        wait_cyc(3);
        rst = 0;
        wait_cyc(2);
    endtask

    function automatic int rlen();
        return ($urandom_range(5, 0) == 0) ? $urandom_range(DW, 5)
                                           : $urandom_range(32, DW + 1);
    endfunction

    logic [DW-1:0] fl[8], fr[8];
    bit done;

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        wait_cyc(3);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_irq", irq, 0);
        rst = 0;
        wait_cyc(2);

        // One frame
        rdy = 1; beats.delete();
        slot(1, '0, 4);
        frame(24'hA5A5A5, 24'h5A5A5A);
        wait_cyc(10);
        chk("s1_beats", beats.size(), 1);
        chk("s1_data", beat(0), 48'h5A5A5AA5A5A5);

        // Reset released mid left slot
        lr = 0; sclk = 0;
        do_reset();
        beats.delete();
        for (int i = 0; i < 2; i++) begin fl[i] = DW'($urandom); fr[i] = DW'($urandom); end
        slot(0, DW'($urandom), 10);
        slot(1, DW'($urandom), 32);
        frame(fl[0], fr[0]);
        frame(fl[1], fr[1]);
        wait_cyc(10);
        chk("s2_beats", beats.size(), 2);
        chk("s2_b0", beat(0), {fr[0], fl[0]});
        chk("s2_b1", beat(1), {fr[1], fl[1]});

        // Overflow with m_tready low
        rdy = 0;
        do_reset();
        beats.delete();
        slot(1, '0, 4);
        for (int i = 0; i < 6; i++) begin
            fl[i] = DW'($urandom); fr[i] = DW'($urandom);
            frame(fl[i], fr[i]);
        end
        wait_cyc(10);
        chk("s3_ovf", ovf, 2);
        chk("s3_tvalid", tvalid, 1);
        chk("s3_irq", irq, IRQ_ON);
        iclr = 1;
        wait_cyc(1);
        iclr = 0;
        chk("s3_irq_clr", irq, 0);
        rdy = 1;
        wait_cyc(10);
        chk("s3_beats", beats.size(), 4);
        for (int i = 0; i < 4; i++) chk("s3_data", beat(i), {fr[i], fl[i]});

        // Short left slot
        do_reset();
        beats.delete(); nerr = 0;
        slot(1, '0, 4);
        slot(0, DW'($urandom), 11);
        slot(1, DW'($urandom), 32);
        fl[0] = DW'($urandom); fr[0] = DW'($urandom);
        frame(fl[0], fr[0]);
        wait_cyc(10);
        chk("s4_ferr_pulses", nerr, 1);
        chk("s4_irq", irq, IRQ_ON);
        chk("s4_beats", beats.size(), 1);
        chk("s4_data", beat(0), {fr[0], fl[0]});

        // Full FIFO popped on the push cycle
        rdy = 0;
        do_reset();
        beats.delete();
        slot(1, '0, 4);
        for (int i = 0; i < 5; i++) begin fl[i] = DW'($urandom); fr[i] = DW'($urandom); end
        for (int i = 0; i < 4; i++) frame(fl[i], fr[i]);
        slot(0, fl[4], 32);
        for (int i = 0; i < 32; i++) begin
            if (i == DW) begin
                lr = 1; sd = fr[4][0]; sclk = 0;
                wait_cyc(3);
                sclk = 1;
                @(posedge clk); @(posedge clk); #2;
                rdy = 1;
                wait_cyc(1);
                rdy = 0;
                wait_cyc(2);
            end else begin
                sbit(1, (i >= 1 && i <= DW) ? fr[4][DW-i] : 1'($urandom));
            end
        end
        wait_cyc(5);
        chk("s5_ovf", ovf, 0);
        chk("s5_popped", beats.size(), 1);
        chk("s5_tvalid", tvalid, 1);
        rdy = 1;
        wait_cyc(10);
        chk("s5_beats", beats.size(), 5);
        chk("s5_last", beat(4), {fr[4], fl[4]});

        // Reset mid right slot with entries queued
        rdy = 0;
        do_reset();
        slot(1, '0, 4);
        frame(DW'($urandom), DW'($urandom));
        frame(DW'($urandom), DW'($urandom));
        slot(0, DW'($urandom), 32);
        slot(1, DW'($urandom), 12);
        chk("s6_tvalid_before", tvalid, 1);
        rst = 1;
        #1;
        chk("s6_tvalid_async", tvalid, 0);
        wait_cyc(3);
        rst = 0;
        rdy = 1; beats.delete();
        slot(1, DW'($urandom), 20);
        wait_cyc(20);
        chk("s6_no_beat", beats.size(), 0);
        fl[0] = DW'($urandom); fr[0] = DW'($urandom);
        frame(fl[0], fr[0]);
        wait_cyc(10);
        chk("s6_beats", beats.size(), 1);
        chk("s6_data", beat(0), {fr[0], fl[0]});

        // Randomized traffic, irregular slots and back-pressure
        do_reset();
        done = 0;
        fork
            begin
                slot(1, DW'($urandom), 4);
                for (int f = 0; f < 25; f++) begin
                    slot(0, DW'($urandom), rlen());
                    slot(1, DW'($urandom), rlen());
                end
                wait_cyc(20);
                done = 1;
            end
            begin
                while (!done) begin
                    rdy  = 1'($urandom);
                    iclr = ($urandom_range(7, 0) == 0);
                    wait_cyc(1);
                end
            end
        join
        rdy = 1; iclr = 0;
        wait_cyc(20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
